// File: rtl/fir_sched_pkg.sv
// rtl/fir_sched_pkg.sv - shared state encoding and widths for the FIR bank sample scheduler
package fir_sched_pkg;
   localparam int SAMPLE_W          = 16;
   localparam int FIR_CHANNELS      = 8;
   localparam int RESULT_W          = SAMPLE_W * FIR_CHANNELS;
   localparam int DEF_FRAME_CYCLES  = 76;
   localparam int DEF_CAPTURE_DELAY = 72;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_CAPTURE,
      ST_GAP
   } sched_state_t;
endpackage

// File: rtl/fir_sched_fifo.sv
// rtl/fir_sched_fifo.sv - synchronous FIFO with registered occupancy count and full/empty flags
module fir_sched_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          push_ok;
   logic          pop_ok;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/fir_sample_scheduler.sv
// rtl/fir_sample_scheduler.sv - feeds queued samples to the 8-channel FIR bank and streams captured results
// Optional stall_count output enabled by defining FIR_SCHED_STALL_CNT_EN.
module fir_sample_scheduler
   import fir_sched_pkg::*;
#(
   parameter int FIFO_DEPTH    = 4,
   parameter int CAPTURE_DELAY = DEF_CAPTURE_DELAY,
   parameter int FRAME_CYCLES  = DEF_FRAME_CYCLES
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [SAMPLE_W-1:0] s_data,
   input  logic                s_valid,
   output logic                s_ready,
   output logic [SAMPLE_W-1:0] fir_datain,
   output logic                fir_din_enable,
   input  logic [RESULT_W-1:0] fir_dataout,
   output logic [RESULT_W-1:0] m_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic                busy
`ifdef FIR_SCHED_STALL_CNT_EN
   ,
   output logic [15:0]         stall_count
`endif
);
   localparam int CW = $clog2(FRAME_CYCLES + 1);
   localparam logic [CW-1:0] CAP_LAST = CW'(CAPTURE_DELAY - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(FRAME_CYCLES - 2);
   localparam logic [CW-1:0] CNT_MAX  = CW'(FRAME_CYCLES);

   sched_state_t        state;
   logic [CW-1:0]       frame_cnt;
   logic [CW-1:0]       gap_cnt;
   logic [CW-1:0]       frame_nxt;
   logic [CW-1:0]       gap_nxt;
   logic [SAMPLE_W-1:0] fifo_head;
   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_pop;
   logic                capture_go;

   assign s_ready    = !reset && !fifo_full;
   assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;
   assign capture_go = !m_valid || m_ready;
   assign frame_nxt  = frame_cnt + CW'(1);
   assign gap_nxt    = (gap_cnt == CNT_MAX) ? gap_cnt : gap_cnt + CW'(1);

   fir_sched_fifo #(
      .DEPTH(FIFO_DEPTH),
      .W    (SAMPLE_W)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (s_valid && s_ready),
      .push_data(s_data),
      .pop      (fifo_pop),
      .pop_data (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Counter thresholds compare the post-increment value so the load edge lands
   // CAPTURE_DELAY cycles after din_enable falls and issues stay FRAME_CYCLES apart.
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= ST_IDLE;
         fir_datain     <= '0;
         fir_din_enable <= 1'b0;
         m_data         <= '0;
         m_valid        <= 1'b0;
         busy           <= 1'b0;
         frame_cnt      <= '0;
         gap_cnt        <= '0;
      end else begin
         fir_din_enable <= 1'b0;
         if (m_valid && m_ready) m_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  fir_datain     <= fifo_head;
                  fir_din_enable <= 1'b1;
                  busy           <= 1'b1;
                  state          <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               frame_cnt <= '0;
               gap_cnt   <= '0;
               state     <= ST_WAIT;
            end
            ST_WAIT: begin
               frame_cnt <= frame_nxt;
               gap_cnt   <= gap_nxt;
               if (frame_nxt == CAP_LAST) state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               gap_cnt <= gap_nxt;
               if (capture_go) begin
                  m_data  <= fir_dataout;
                  m_valid <= 1'b1;
                  state   <= ST_GAP;
               end
            end
            ST_GAP: begin
               gap_cnt <= gap_nxt;
               if (gap_nxt >= GAP_LAST) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef FIR_SCHED_STALL_CNT_EN
   always_ff @(posedge clock) begin
      if (reset)
         stall_count <= '0;
      else if ((state == ST_CAPTURE) && m_valid && !m_ready && (stall_count != 16'hFFFF))
         stall_count <= stall_count + 16'd1;
   end
`endif
endmodule

// File: tb/tb_fir_sample_scheduler.sv
// tb/tb_fir_sample_scheduler.sv - directed self-checking bench for fir_sample_scheduler
module tb_fir_sample_scheduler;
   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [15:0]  s_data = '0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [15:0]  fir_datain;
   logic         fir_din_enable;
   logic [127:0] fir_dataout;
   logic [127:0] m_data;
   logic         m_valid;
   logic         m_ready = 1'b0;
   logic         busy;
`ifdef FIR_SCHED_STALL_CNT_EN
   logic [15:0]  stall_count;
`endif

   fir_sample_scheduler dut (
      .clock         (clock),
      .reset         (reset),
      .s_data        (s_data),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .fir_datain    (fir_datain),
      .fir_din_enable(fir_din_enable),
      .fir_dataout   (fir_dataout),
      .m_data        (m_data),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .busy          (busy)
`ifdef FIR_SCHED_STALL_CNT_EN
      ,
      .stall_count   (stall_count)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0]  sample;
      logic [127:0] exp_data;
   } vec_t;

   int           cyc = 0;
   int           n_checks = 0;
   int           n_fail = 0;
   int           en_times[$];
   logic [127:0] got[$];
   vec_t         tbl[6];

   function automatic logic [127:0] bank_out(input logic [15:0] s);
      logic [127:0] r;
      for (int k = 0; k < 8; k++) r[k*16 +: 16] = s + 16'(k) * 16'h0101;
      return r;
   endfunction

   always @(posedge clock) cyc <= cyc + 1;

   // Bank model: outputs change once per din_enable and then hold.
   always @(posedge clock) begin
      if (reset) fir_dataout <= '0;
      else if (fir_din_enable) fir_dataout <= bank_out(fir_datain);
   end

   always @(negedge clock) begin
      if (!reset && fir_din_enable) en_times.push_back(cyc);
      if (!reset && m_valid && m_ready) got.push_back(m_data);
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out", name);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_one(input logic [15:0] d, output int at);
      logic ok;
      ok = 1'b0;
      s_data = d;
      s_valid = 1'b1;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clock);
         ok = s_ready;
         tick();
      end
      s_valid = 1'b0;
      at = cyc;
      if (!ok) timeout("push");
   endtask

   task automatic wait_valid(output int at);
      at = -1;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (m_valid) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) timeout("m_valid");
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 400 && busy; i++) tick();
      if (busy) timeout("idle");
   endtask

   initial begin
      int t0, t1, p, p2, drops_after, i;
      logic r, seen_low, en_at_recover;

      tbl[0] = '{16'h0001, bank_out(16'h0001)};
      tbl[1] = '{16'hFFFF, bank_out(16'hFFFF)};
      tbl[2] = '{16'h8000, bank_out(16'h8000)};
      tbl[3] = '{16'h7FFF, bank_out(16'h7FFF)};
      tbl[4] = '{16'hA5A5, bank_out(16'hA5A5)};
      tbl[5] = '{16'h5A5A, bank_out(16'h5A5A)};

      repeat (3) tick();
      @(negedge clock);
      check("rst_s_ready", s_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_din_enable", fir_din_enable, 0);
      check("rst_m_data", m_data, 0);
      check("rst_fir_datain", fir_datain, 0);
      reset = 1'b0;
      tick();
      check("post_rst_s_ready", s_ready, 1);

      // Single sample
      push_one(16'h1234, t0);
      check("single_en_before", fir_din_enable, 0);
      tick();
      check("single_en_high", fir_din_enable, 1);
      check("single_datain", fir_datain, 16'h1234);
      check("single_busy", busy, 1);
      tick();
      check("single_en_low", fir_din_enable, 0);
      wait_valid(t1);
      check("single_latency", 128'(t1 - t0), 128'd74);
      check("single_m_data", m_data, bank_out(16'h1234));
      m_ready = 1'b1;
      tick();
      check("single_m_valid_clear", m_valid, 0);
      check("single_datain_hold", fir_datain, 16'h1234);

      // Burst of six with m_ready held high
      wait_idle();
      got.delete();
      en_times.delete();
      drops_after = -1;
      seen_low = 1'b0;
      en_at_recover = 1'b0;
      for (int v = 0; v < 6; v++) begin
         s_data = tbl[v].sample;
         s_valid = 1'b1;
         r = 1'b0;
         for (int k = 0; k < 400 && !r; k++) begin
            @(negedge clock);
            r = s_ready;
            if (!r && !seen_low) begin
               seen_low = 1'b1;
               drops_after = v;
            end else if (r && seen_low && drops_after == v) begin
               en_at_recover = fir_din_enable;
            end
            tick();
         end
         s_valid = 1'b0;
         if (!r) timeout("burst_push");
      end
      check("burst_ready_drop", 128'(drops_after), 128'd5);
      check("burst_no_bypass", en_at_recover, 1);
      for (i = 0; i < 1000 && got.size() < 6; i++) tick();
      check("burst_count", 128'(got.size()), 128'd6);
      for (int v = 0; v < 6 && v < got.size(); v++)
         check($sformatf("burst_data%0d", v), got[v], tbl[v].exp_data);
      check("burst_en_count", 128'(en_times.size()), 128'd6);
      for (int v = 1; v < 6 && v < en_times.size(); v++)
         check($sformatf("burst_spacing%0d", v), 128'(en_times[v] - en_times[v-1]), 128'd76);

      // Backpressure with two queued samples, then same-edge accept and reload
      wait_idle();
      m_ready = 1'b0;
      push_one(16'h1357, p);
      push_one(16'h2468, p2);
      check("bp_push_b2b", 128'(p2 - p), 128'd1);
      repeat (200) tick();
      check("bp_m_valid", m_valid, 1);
      check("bp_m_data_held", m_data, bank_out(16'h1357));
      check("bp_busy_stalled", busy, 1);
`ifdef FIR_SCHED_STALL_CNT_EN
      check("bp_stall_count", stall_count, 16'd52);
`endif
      m_ready = 1'b1;
      tick();
      check("sim_m_valid_kept", m_valid, 1);
      check("sim_m_data_new", m_data, bank_out(16'h2468));
      tick();
      check("sim_m_valid_clear", m_valid, 0);
`ifdef FIR_SCHED_STALL_CNT_EN
      check("bp_stall_final", stall_count, 16'd52);
`endif

      // Reset in the middle of a frame with a second sample still queued
      wait_idle();
      push_one(16'h0F0F, t0);
      push_one(16'hF0F0, t1);
      repeat (39) tick();
      reset = 1'b1;
      tick();
      check("mid_rst_datain", fir_datain, 0);
      check("mid_rst_en", fir_din_enable, 0);
      check("mid_rst_m_data", m_data, 0);
      check("mid_rst_m_valid", m_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_s_ready", s_ready, 0);
      reset = 1'b0;
      en_times.delete();
      repeat (10) tick();
      check("mid_rst_fifo_empty", 128'(en_times.size()), 128'd0);
      check("mid_rst_idle", busy, 0);
      check("mid_rst_s_ready_back", s_ready, 1);
      push_one(16'h4321, t0);
      wait_valid(t1);
      check("post_rst_latency", 128'(t1 - t0), 128'd74);
      check("post_rst_m_data", m_data, bank_out(16'h4321));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fir_sample_scheduler.md
# fir_sample_scheduler

- Sequences the 8-channel FIR bank (`profir`).
- Accepts input samples over a valid/ready stream into a small FIFO.
- Issues each sample to the bank with a single-cycle `din_enable` pulse, spaced by the bank's frame period.
- Captures the eight 16-bit channel outputs once the frame completes and presents them as one 128-bit result beat on a valid/ready output stream.

## Interface
- `FIFO_DEPTH`, default 4: input FIFO entries; power of two, ≥2.
- `CAPTURE_DELAY`, default 72: cycles from the `fir_din_enable` falling edge to the `m_data` load edge. Must exceed the bank's processing time.
- `FRAME_CYCLES`, default 76: minimum cycles between consecutive ISSUE entries. Must be greater than CAPTURE_DELAY+1.
- `clock`  in  1: clock, rising-edge.
- `reset`  in  1: reset, synchronous, active-high. The same reset drives the FIR bank.
- `s_data`  in  16: signed input sample.
- `s_valid`  in  1: input sample valid.
- `s_ready`  out  1: FIFO not full.
- `fir_datain`  out  16: sample to the bank; registered.
- `fir_din_enable`  out  1: start pulse to the bank.
- `fir_dataout`  in  128: bank outputs packed; channel k occupies [16k+15:16k].
- `m_data`  out  128: captured channel results, same packing.
- `m_valid`  out  1: result valid.
- `m_ready`  in  1: result accepted.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- **States:** IDLE, ISSUE, WAIT, CAPTURE, GAP.
- **IDLE:** on a rising edge with the FIFO non-empty, go to ISSUE.
  - On that same edge, pop the FIFO head into `fir_datain`.
  - `fir_datain` then holds this value until the next pop.
- **ISSUE:** lasts exactly one cycle.
  - `fir_din_enable` = 1 only in this state.
  - Clear `frame_cnt` and `gap_cnt` to 0; go to WAIT.
- **WAIT:** `frame_cnt` and `gap_cnt` increment every cycle. When `frame_cnt` == CAPTURE_DELAY-1, go to CAPTURE.
- **CAPTURE:** `gap_cnt` keeps incrementing.
  - If `m_valid` = 0 or `m_ready` = 1: load `m_data` ← `fir_dataout`, set `m_valid` = 1, go to GAP.
  - Otherwise stay in CAPTURE (stall). Stalling is safe because the bank's outputs stay stable until the next `din_enable`.
- **GAP:** `gap_cnt` increments. When `gap_cnt` ≥ FRAME_CYCLES-2, go to IDLE. The same-edge pop rule applies, so back-to-back frames are FRAME_CYCLES apart.
- **Output handshake:** `m_valid` clears on an edge where `m_valid` && `m_ready`, except when CAPTURE loads on that same edge, in which case it stays 1 with the new data.
- **FIFO:**
  - Push when `s_valid` && `s_ready`; `s_ready` = !full, registered count, no bypass.
  - Push and pop on the same edge leave the count unchanged.
  - When full, `s_ready` = 0 even while a pop occurs that cycle.
- **Arithmetic:** `frame_cnt`/`gap_cnt` width is $clog2(FRAME_CYCLES+1). `gap_cnt` saturates at FRAME_CYCLES.
- **Reset** (any state, including mid-frame):
  - Return to IDLE and empty the FIFO.
  - `fir_datain` = 0, `fir_din_enable` = 0, `m_data` = 0, `m_valid` = 0, `busy` = 0, `s_ready` = 0 during reset and 1 afterwards, stall counter = 0.
  - Any in-flight frame is discarded.

## Timing
- A sample accepted at edge N into an empty FIFO with the FSM in IDLE:
  - `fir_din_enable` is high between edges N+1 and N+2.
  - `m_valid` rises at edge N+2+CAPTURE_DELAY, if not stalled.
- Capture stall extends the frame by the stall length. The next ISSUE happens no earlier than FRAME_CYCLES after the previous one.
- Output is one result per accepted sample, in order, with none dropped.

## Configuration
- **`FIR_SCHED_STALL_CNT_EN` defined:**
  - Adds output `stall_count` (out, 16 bits).
  - It counts cycles spent in CAPTURE with `m_valid` && !`m_ready`, saturating at 0xFFFF, and is cleared by reset.
- **Undefined:** the port and counter are absent; behaviour is otherwise identical.

## Structure
- **`fir_sched_pkg`:** state enum; constants SAMPLE_W = 16, FIR_CHANNELS = 8, RESULT_W = 128; default FRAME_CYCLES/CAPTURE_DELAY.
- **Sub-module `fir_sched_fifo`:** parameterised sync FIFO with registered count and full/empty flags. The FSM lives in the top level.

## Test plan
- **Single sample:** after reset, push 0x1234 at edge 10 → `fir_datain` = 0x1234 and `fir_din_enable` high for cycle 11–12 only; `m_valid` rises at edge 84 with `m_data` = the bank outputs at that edge.
- **Burst:** push 6 samples back-to-back with `m_ready` = 1 → `s_ready` drops after 4 are buffered; `din_enable` pulses exactly 76 cycles apart; 6 results in order.
- **Backpressure:** hold `m_ready` = 0 for 200 cycles with 2 samples queued → the second frame stalls in CAPTURE; no result lost or overwritten; with the macro defined, `stall_count` equals the stalled cycles.
- **Simultaneous events:** `m_ready` = 1 on the CAPTURE load edge with `m_valid` = 1 → `m_valid` stays 1 and `m_data` takes the new value. Push and pop on the same edge with the FIFO full → count unchanged.
- **Reset mid-frame:** assert `reset` at edge 40 of a frame → all outputs 0, FIFO empty, IDLE; the next pushed sample completes a normal frame.
